branch_resolve: RTL and testbench

//  Consumer end of the fetch redirect/tag protocol. Sits at the execute/retire boundary: receives
//  (tag, NPC) per instruction, kills wrong-path instructions whose tag differs from the expected
//  tag, and drives a one-cycle non-zero NewPC pulse when an accepted instruction resolves a taken

---
 rtl/branch_resolve.sv | 98 +++++++++
 tb/tb_branch_resolve.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Execute/retire-side consumer of the fetch redirect/tag protocol: filters wrong-path
// instructions by tag, and issues a single-cycle redirect pulse for each accepted taken jump.
module branch_resolve #(
  parameter int TAG_W     = 4,
  parameter int DRAIN_MAX = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [31:0]      npc_in,
  input  logic             jump_req,
  input  logic [31:0]      jump_target,
  output logic [31:0]      new_pc,
  output logic             valid_out,
  output logic [31:0]      npc_out,
  output logic [TAG_W-1:0] exp_tag,
  output logic [CNT_W-1:0] killed_cnt,
  output logic             target_err,
  output logic             drain_err
);

  typedef enum logic [1:0] {RUN, REDIRECT, DRAIN} state_t;

  localparam int DC_W = $clog2(DRAIN_MAX + 1);
  localparam logic [DC_W-1:0] DMAX = DC_W'(DRAIN_MAX);

  state_t           state_q;
  logic [31:0]      new_pc_q;
  logic             valid_q;
  logic [31:0]      npc_q;
  logic [TAG_W-1:0] exp_tag_q;
  logic [CNT_W-1:0] killed_q;
  logic             terr_q;
  logic             derr_q;
  logic [DC_W-1:0]  dcnt_q;

  logic accept, kill;

  // Everything is killed during the redirect cycle, including a matching tag.
  assign accept = valid_in && (tag_in == exp_tag_q) && (state_q != REDIRECT);
  assign kill   = valid_in && !accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      new_pc_q  <= '0;
      valid_q   <= 1'b0;
      npc_q     <= '0;
      exp_tag_q <= '0;
      killed_q  <= '0;
      terr_q    <= 1'b0;
      derr_q    <= 1'b0;
      dcnt_q    <= '0;
    end else begin
      valid_q  <= accept;
      new_pc_q <= '0;
      if (accept) npc_q <= npc_in;
      if (kill && killed_q != {CNT_W{1'b1}}) killed_q <= killed_q + 1'b1;

      case (state_q)
        REDIRECT: begin
          state_q <= DRAIN;
          dcnt_q  <= '0;
        end
        default: begin
          // Drain timeout counter holds at DRAIN_MAX once the error has fired.
          if (state_q == DRAIN && !accept && dcnt_q != DMAX) begin
            dcnt_q <= dcnt_q + 1'b1;
            if (dcnt_q == DMAX - 1'b1) derr_q <= 1'b1;
          end
          if (accept) begin
            state_q <= RUN;
            if (jump_req) begin
              if (jump_target != '0) begin
                new_pc_q  <= jump_target;
                exp_tag_q <= exp_tag_q + 1'b1;
                state_q   <= REDIRECT;
              end else begin
                terr_q <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign new_pc     = new_pc_q;
  assign valid_out  = valid_q;
  assign npc_out    = npc_q;
  assign exp_tag    = exp_tag_q;
  assign killed_cnt = killed_q;
  assign target_err = terr_q;
  assign drain_err  = derr_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a behavioural model of the tag/redirect protocol.
module tb_branch_resolve;

  localparam int TAG_W = 4;
  localparam int DMAX  = 8;
  localparam int CNT_W = 5;
  localparam int KMAX  = (1 << CNT_W) - 1;
  localparam int NTAG  = 1 << TAG_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in;
  logic [TAG_W-1:0] tag_in;
  logic [31:0]      npc_in;
  logic             jump_req;
  logic [31:0]      jump_target;
  logic [31:0]      new_pc;
  logic             valid_out;
  logic [31:0]      npc_out;
  logic [TAG_W-1:0] exp_tag;
  logic [CNT_W-1:0] killed_cnt;
  logic             target_err;
  logic             drain_err;

  branch_resolve #(.TAG_W(TAG_W), .DRAIN_MAX(DMAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .tag_in(tag_in), .npc_in(npc_in),
    .jump_req(jump_req), .jump_target(jump_target), .new_pc(new_pc), .valid_out(valid_out),
    .npc_out(npc_out), .exp_tag(exp_tag), .killed_cnt(killed_cnt), .target_err(target_err),
    .drain_err(drain_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural model: "redirect pending" and "draining" phases, counts as plain ints.
  bit          m_redir, m_drain;
  int          m_dcyc, m_tag, m_kill;
  bit          m_vo, m_terr, m_derr;
  logic [31:0] m_npc, m_newpc;

  task automatic model_reset();
    m_redir = 0; m_drain = 0; m_dcyc = 0; m_tag = 0; m_kill = 0;
    m_vo = 0; m_terr = 0; m_derr = 0; m_npc = 0; m_newpc = 0;
  endtask

  task automatic model_step();
    bit acc, kil;
    acc = valid_in && (int'(tag_in) == m_tag) && !m_redir;
    kil = valid_in && !acc;
    m_vo = acc;
    m_newpc = 0;
    if (acc) m_npc = npc_in;
    if (kil && m_kill < KMAX) m_kill++;
    if (m_redir) begin
      m_redir = 0; m_drain = 1; m_dcyc = 0;
    end else begin
      if (m_drain && !acc) begin
        m_dcyc++;
        if (m_dcyc >= DMAX) m_derr = 1;
      end
      if (acc) begin
        m_drain = 0;
        if (jump_req) begin
          if (jump_target != 0) begin
            m_newpc = jump_target;
            m_tag = (m_tag + 1) % NTAG;
            m_redir = 1;
          end else m_terr = 1;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("new_pc", new_pc, m_newpc);
    chk("valid_out", {31'd0, valid_out}, {31'd0, m_vo});
    if (m_vo) chk("npc_out", npc_out, m_npc);
    chk("exp_tag", 32'(exp_tag), 32'(m_tag));
    chk("killed_cnt", 32'(killed_cnt), 32'(m_kill));
    chk("target_err", {31'd0, target_err}, {31'd0, m_terr});
    chk("drain_err", {31'd0, drain_err}, {31'd0, m_derr});
  endtask

  // One clock: drive inputs, step the model on the edge, sample 1 time unit later.
  task automatic cyc(input logic v, input int tag, input logic [31:0] pc,
                     input logic jr, input logic [31:0] tgt);
    valid_in = v; tag_in = TAG_W'(tag); npc_in = pc; jump_req = jr; jump_target = tgt;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    valid_in = 0; tag_in = 0; npc_in = 0; jump_req = 0; jump_target = 0;
    model_reset();
    @(posedge clk); #1;
    check_model();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    model_step();
  endtask

  task automatic jump_pair(input logic [31:0] pc, input logic [31:0] tgt);
    cyc(1, m_tag, pc, 1, tgt);
    cyc(0, 0, 0, 1, 32'h4);
  endtask

  typedef struct {
    logic v; int tag; logic [31:0] npc; logic jr; logic [31:0] tgt;
    logic evo; logic [31:0] enpc; logic [31:0] enew; int etag; int ekill;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 0, 32'h00,  1'b0, 32'h0,   1'b1, 32'h00,  32'h0,   0, 0};
    tbl[1] = '{1'b1, 0, 32'h04,  1'b0, 32'h0,   1'b1, 32'h04,  32'h0,   0, 0};
    tbl[2] = '{1'b1, 0, 32'h08,  1'b0, 32'h0,   1'b1, 32'h08,  32'h0,   0, 0};
    tbl[3] = '{1'b1, 0, 32'h0C,  1'b1, 32'h100, 1'b1, 32'h0C,  32'h100, 1, 0};
    tbl[4] = '{1'b0, 0, 32'h10,  1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   1, 0};
    tbl[5] = '{1'b1, 0, 32'h10,  1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   1, 1};
    tbl[6] = '{1'b1, 0, 32'h14,  1'b1, 32'h200, 1'b0, 32'h0,   32'h0,   1, 2};
    tbl[7] = '{1'b1, 0, 32'h18,  1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   1, 3};
    tbl[8] = '{1'b1, 1, 32'h100, 1'b0, 32'h0,   1'b1, 32'h100, 32'h0,   1, 3};
    tbl[9] = '{1'b1, 1, 32'h104, 1'b0, 32'h0,   1'b1, 32'h104, 32'h0,   1, 3};

    do_reset();
    chk("rst_exp_tag", 32'(exp_tag), 32'd0);

    // Streaming, first jump, and DRAIN kill/accept
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].v, tbl[i].tag, tbl[i].npc, tbl[i].jr, tbl[i].tgt);
      chk($sformatf("vec%0d_valid", i), {31'd0, valid_out}, {31'd0, tbl[i].evo});
      if (tbl[i].evo) chk($sformatf("vec%0d_npc", i), npc_out, tbl[i].enpc);
      chk($sformatf("vec%0d_newpc", i), new_pc, tbl[i].enew);
      chk($sformatf("vec%0d_tag", i), 32'(exp_tag), 32'(tbl[i].etag));
      chk($sformatf("vec%0d_kill", i), 32'(killed_cnt), 32'(tbl[i].ekill));
    end

    // Tag wrap: bring exp_tag to 15, then 16 jumps
    while (m_tag != NTAG - 1) jump_pair(32'h1000, 32'h2000);
    chk("pre_wrap_tag", 32'(exp_tag), 32'd15);
    for (int j = 0; j < 16; j++) jump_pair(32'h3000 + 32'(j * 4), 32'h4000 + 32'(j * 16));
    chk("wrap_tag", 32'(exp_tag), 32'd15);
    jump_pair(32'h3100, 32'h5000);
    chk("wrapped_tag", 32'(exp_tag), 32'd0);
    cyc(1, 0, 32'h5000, 0, 0);
    chk("wrap_accept", {31'd0, valid_out}, 32'd1);
    chk("wrap_accept_npc", npc_out, 32'h5000);

    // Jump to address 0 is flagged, not taken
    cyc(1, 0, 32'h5004, 1, 32'h0);
    chk("tz_err", {31'd0, target_err}, 32'd1);
    chk("tz_newpc", new_pc, 32'd0);
    chk("tz_tag", 32'(exp_tag), 32'd0);
    cyc(1, 0, 32'h5008, 0, 0);
    chk("tz_still_run", {31'd0, valid_out}, 32'd1);

    // Drain timeout, then async reset in the middle of DRAIN
    jump_pair(32'h500C, 32'h6000);
    for (int j = 0; j < DMAX - 1; j++) cyc(1, 0, 32'h6000, 0, 0);
    chk("drain_before_max", {31'd0, drain_err}, 32'd0);
    cyc(1, 0, 32'h6000, 0, 0);
    chk("drain_at_max", {31'd0, drain_err}, 32'd1);
    cyc(1, 3, 32'h6000, 0, 0);
    chk("drain_sticky", {31'd0, drain_err}, 32'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("async_newpc", new_pc, 32'd0);
    chk("async_valid", {31'd0, valid_out}, 32'd0);
    chk("async_npc", npc_out, 32'd0);
    chk("async_tag", 32'(exp_tag), 32'd0);
    chk("async_kill", 32'(killed_cnt), 32'd0);
    chk("async_terr", {31'd0, target_err}, 32'd0);
    chk("async_derr", {31'd0, drain_err}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    cyc(1, 0, 32'h7000, 0, 0);
    chk("post_rst_accept", {31'd0, valid_out}, 32'd1);

    // Randomized traffic against the model, with one mid-run reset
    for (int r = 0; r < 3000; r++) begin
      int t;
      logic [31:0] tg;
      if (r == 1500) do_reset();
      t  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NTAG - 1)) : m_tag;
      tg = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h4);
      cyc(logic'($urandom_range(0, 4) != 0), t, $urandom, logic'($urandom_range(0, 9) < 3), tg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
